// File: rtl/trng_seq_ctrl.sv
// trng_seq_ctrl
//   Sequencer and register front-end for the ring-oscillator TRNG.
//   The block gates the oscillator bank and paces sampling of its raw bit.
//   It throws away warm-up samples and runs a repetition-count health test.
//   It packs accepted bits into bytes and queues them in a small FIFO.
//   The CPU reads the queued bytes through 8-bit registers.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   address      : register select (0 CTRL, 1 STATUS, 2 DATA, 3 RCT_LIMIT)
//   data_write   : write strobe, data_in valid
//   data_in      : write data
//   data_read    : one-cycle read strobe; a read of DATA pops the FIFO
//   data_out     : read data, combinational on address
//   entropy_bit  : raw sampled oscillator bit
//   ro_enable    : oscillator bank enable
//   byte_ready   : high while the FIFO holds at least one byte
module trng_seq_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int WARMUP_BITS = 32,
  parameter int RCT_RESET   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  input  logic       data_read,
  output logic [7:0] data_out,
  input  logic       entropy_bit,
  output logic       ro_enable,
  output logic       byte_ready
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int WARM_W = $clog2(WARMUP_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_COLLECT,
    ST_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic               enable_q, enable_d;
  logic [3:0]         div_q, div_d;
  logic [7:0]         rct_limit_q, rct_limit_d;
  logic [7:0]         presc_q, presc_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               last_bit_q, last_bit_d;
  logic [7:0]         run_q, run_d;
  logic               health_fail_q, health_fail_d;
  logic [7:0]         fifo_mem_q [FIFO_DEPTH];
  logic [7:0]         fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;

  logic       ctrl_wr, rct_wr, fifo_clear;
  logic       pop, push, full, strobe, accept;
  logic [7:0] run_next;
  logic       rct_hit;
  logic [2:0] level_field;

  assign ctrl_wr    = data_write && (address == 4'h0);
  assign rct_wr     = data_write && (address == 4'h3);
  assign fifo_clear = ctrl_wr && data_in[1];
  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop        = data_read && (address == 4'h2) && (level_q != '0);
  assign ro_enable  = (state_q == ST_WARMUP) || (state_q == ST_COLLECT);
  assign byte_ready = (level_q != '0);

  // The ">=" keeps the prescaler from running away to 255 if div is
  // lowered while the count is already past the new value.
  assign strobe = ro_enable && (presc_q >= {4'h0, div_q});

  // Prescaler only runs while the oscillators are on, so every enable
  // starts sampling from a fresh count.
  always_comb begin
    presc_d = presc_q;
    if (!ro_enable || strobe) begin
      presc_d = 8'h00;
    end else begin
      presc_d = presc_q + 8'd1;
    end
  end

  // Repetition-count update for the sample on entropy_bit this cycle.
  // A zero run count marks "no previous bit" right after entering warm-up.
  always_comb begin
    run_next = 8'd1;
    if ((run_q != 8'd0) && (entropy_bit == last_bit_q)) begin
      run_next = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    end
    rct_hit = (run_next >= rct_limit_q);
  end

  // Sequencer, byte assembly, register writes and FIFO bookkeeping.
  // A full FIFO blocks sampling unless a pop frees a slot in the same cycle.
  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    div_d         = div_q;
    rct_limit_d   = rct_limit_q;
    warm_cnt_d    = warm_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    last_bit_d    = last_bit_q;
    run_d         = run_q;
    health_fail_d = health_fail_q;
    fifo_mem_d    = fifo_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    push          = 1'b0;
    accept        = 1'b0;

    case (state_q)
      ST_WARMUP: begin
        if (strobe) begin
          last_bit_d = entropy_bit;
          run_d      = run_next;
          if (rct_hit) begin
            state_d       = ST_FAIL;
            health_fail_d = 1'b1;
          end else if (warm_cnt_q == WARM_W'(WARMUP_BITS - 1)) begin
            state_d    = ST_COLLECT;
            warm_cnt_d = '0;
            bit_cnt_d  = 3'd0;
          end else begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
          end
        end
      end
      ST_COLLECT: begin
        accept = strobe && (!full || pop);
        if (accept) begin
          last_bit_d = entropy_bit;
          run_d      = run_next;
          if (rct_hit) begin
            state_d       = ST_FAIL;
            health_fail_d = 1'b1;
          end else begin
            shift_d   = {entropy_bit, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            push      = (bit_cnt_q == 3'd7);
          end
        end
      end
      default: ;
    endcase

    if (ctrl_wr) begin
      enable_d = data_in[0];
      div_d    = data_in[7:4];
      if (!data_in[0]) begin
        state_d       = ST_IDLE;
        health_fail_d = 1'b0;
        warm_cnt_d    = '0;
        bit_cnt_d     = 3'd0;
        shift_d       = 8'h00;
        push          = 1'b0;
      end else if (state_q == ST_IDLE) begin
        state_d    = ST_WARMUP;
        warm_cnt_d = '0;
        bit_cnt_d  = 3'd0;
        run_d      = 8'd0;
        last_bit_d = 1'b0;
      end
    end

    // A limit below 2 would fail on every single sample.
    if (rct_wr) begin
      rct_limit_d = (data_in < 8'd2) ? 8'd2 : data_in;
    end

    // Clear wins over a same-cycle push and pop.
    if (fifo_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        fifo_mem_d[wr_ptr_q] = shift_d;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  // State and register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      enable_q      <= 1'b0;
      div_q         <= 4'h0;
      rct_limit_q   <= 8'(RCT_RESET);
      presc_q       <= 8'h00;
      warm_cnt_q    <= '0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      last_bit_q    <= 1'b0;
      run_q         <= 8'd0;
      health_fail_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 8'h00;
      end
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      div_q         <= div_d;
      rct_limit_q   <= rct_limit_d;
      presc_q       <= presc_d;
      warm_cnt_q    <= warm_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      last_bit_q    <= last_bit_d;
      run_q         <= run_d;
      health_fail_q <= health_fail_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      fifo_mem_q    <= fifo_mem_d;
    end
  end

  // STATUS exposes three level bits; with an 8-deep FIFO a full level
  // reads as 0 here and the full flag carries the information.
  assign level_field = 3'(level_q);

  // Register read mux; fifo_clear always reads back as 0.
  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0: data_out = {div_q, 3'b000, enable_q};
      4'h1: data_out = {1'b0, level_field, 1'b0, health_fail_q, full, byte_ready};
      4'h2: data_out = byte_ready ? fifo_mem_q[rd_ptr_q] : 8'h00;
      4'h3: data_out = rct_limit_q;
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_trng_seq_ctrl.sv
// Directed testbench for trng_seq_ctrl: register access, warm-up and
// first-byte timing for two dividers, FIFO full/pop behaviour and byte
// order, the repetition-count health test, FIFO clear and async reset.
module tb_trng_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic       data_read;
  logic [7:0] data_out;
  logic       entropy_bit;
  logic       ro_enable;
  logic       byte_ready;

  int checkCount;
  int errorCount;
  logic [7:0] gotByte;

  trng_seq_ctrl #(
    .FIFO_DEPTH  (4),
    .WARMUP_BITS (32),
    .RCT_RESET   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .data_write  (data_write),
    .data_in     (data_in),
    .data_read   (data_read),
    .data_out    (data_out),
    .entropy_bit (entropy_bit),
    .ro_enable   (ro_enable),
    .byte_ready  (byte_ready)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for every check
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, actual, expected);
    end
  endtask

  // Register write; returns 1 ns after the edge that takes it
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    address    = addr;
    data_in    = data;
    data_write = 1'b1;
    @(posedge clk);
    #1;
    data_write = 1'b0;
    data_in    = 8'h00;
  endtask

  // Side-effect-free register read and compare
  task automatic checkReg(input string tag, input logic [3:0] addr,
                          input logic [7:0] expected);
    address = addr;
    #1;
    checkOutput(tag, data_out, expected);
  endtask

  // Read DATA with the read strobe, which pops at the next edge
  task automatic popData(output logic [7:0] value);
    address   = 4'h2;
    data_read = 1'b1;
    #1;
    value = data_out;
    @(posedge clk);
    #1;
    data_read = 1'b0;
  endtask

  // Present one sample and wait until the strobe edge that takes it
  task automatic sendBit(input logic b, input int div);
    entropy_bit = b;
    repeat (div + 1) @(posedge clk);
    #1;
  endtask

  // Same, but pop DATA on the very edge that takes the sample
  task automatic sendBitPop(input logic b, input int div, output logic [7:0] value);
    entropy_bit = b;
    repeat (div) @(posedge clk);
    #1;
    address   = 4'h2;
    data_read = 1'b1;
    #1;
    value = data_out;
    @(posedge clk);
    #1;
    data_read = 1'b0;
  endtask

  // First n bits of a byte, LSB first (the first bit lands in bit 0)
  task automatic sendBits(input logic [7:0] b, input int n, input int div);
    for (int i = 0; i < n; i++) sendBit(b[i], div);
  endtask

  // 32 alternating warm-up samples 1,0,1,0... ending on 0
  task automatic warmup(input int div);
    for (int i = 0; i < 32; i++) sendBit((i % 2) == 0, div);
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    rst_n       = 1'b0;
    address     = 4'h0;
    data_write  = 1'b0;
    data_in     = 8'h00;
    data_read   = 1'b0;
    entropy_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    checkOutput("rst_ro_enable", ro_enable, 8'h00);
    checkOutput("rst_byte_ready", byte_ready, 8'h00);
    checkReg("rst_ctrl", 4'h0, 8'h00);
    checkReg("rst_status", 4'h1, 8'h00);
    checkReg("rst_rct", 4'h3, 8'h10);
    checkReg("rst_unmapped", 4'h7, 8'h00);

    // div=0: first byte 40 clocks after enable
    applyStimulus(4'h0, 8'h01);
    checkOutput("d0_ro_enable", ro_enable, 8'h01);
    warmup(0);
    checkOutput("d0_after_warmup", byte_ready, 8'h00);
    sendBits(8'h55, 7, 0);
    checkOutput("d0_clk39_ready", byte_ready, 8'h00);
    sendBit(1'b0, 0);
    checkOutput("d0_clk40_ready", byte_ready, 8'h01);
    checkReg("d0_data", 4'h2, 8'h55);
    checkReg("d0_status_lvl1", 4'h1, 8'h11);
    applyStimulus(4'h0, 8'h00);
    checkOutput("d0_disable_ro", ro_enable, 8'h00);
    checkReg("d0_fifo_kept", 4'h1, 8'h11);
    popData(gotByte);
    checkOutput("d0_pop_value", gotByte, 8'h55);
    checkReg("d0_status_lvl0", 4'h1, 8'h00);
    checkReg("d0_data_empty", 4'h2, 8'h00);

    // div=3: first byte 160 clocks after enable, then fill to full
    applyStimulus(4'h0, 8'h31);
    checkReg("d3_ctrl", 4'h0, 8'h31);
    warmup(3);
    sendBits(8'hA3, 7, 3);
    entropy_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("d3_clk159_ready", byte_ready, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("d3_clk160_ready", byte_ready, 8'h01);
    checkReg("d3_data", 4'h2, 8'hA3);
    sendBits(8'h3C, 8, 3);
    sendBits(8'h96, 8, 3);
    sendBits(8'h5A, 8, 3);
    checkReg("full_status", 4'h1, 8'h43);
    sendBits(8'h55, 8, 3);
    checkReg("full_ignored", 4'h1, 8'h43);
    checkOutput("full_ro_enable", ro_enable, 8'h01);
    sendBitPop(1'b1, 3, gotByte);
    checkOutput("full_pop0", gotByte, 8'hA3);
    checkReg("full_pop_lvl3", 4'h1, 8'h31);
    sendBits(8'h62, 6, 3);
    sendBitPop(1'b1, 3, gotByte);
    checkOutput("pushpop_value", gotByte, 8'h3C);
    checkReg("pushpop_lvl3", 4'h1, 8'h31);
    applyStimulus(4'h0, 8'h00);
    popData(gotByte);
    checkOutput("order_b2", gotByte, 8'h96);
    popData(gotByte);
    checkOutput("order_b3", gotByte, 8'h5A);
    popData(gotByte);
    checkOutput("order_b4", gotByte, 8'hC5);
    checkReg("order_empty", 4'h1, 8'h00);

    // Health test during warm-up
    applyStimulus(4'h3, 8'h01);
    checkReg("rct_min_clamp", 4'h3, 8'h02);
    applyStimulus(4'h3, 8'h04);
    checkReg("rct_write", 4'h3, 8'h04);
    applyStimulus(4'h0, 8'h01);
    for (int i = 0; i < 3; i++) sendBit(1'b1, 0);
    checkOutput("rct_before_hit", ro_enable, 8'h01);
    sendBit(1'b1, 0);
    checkOutput("rct_hit_ro", ro_enable, 8'h00);
    checkReg("rct_hit_status", 4'h1, 8'h04);
    applyStimulus(4'h0, 8'h00);
    checkReg("rct_cleared", 4'h1, 8'h00);

    // Health test hitting on the 8th bit: that byte is dropped
    applyStimulus(4'h0, 8'h01);
    warmup(0);
    sendBits(8'h55, 8, 0);
    sendBits(8'hF5, 7, 0);
    checkOutput("rct8_before", ro_enable, 8'h01);
    sendBit(1'b1, 0);
    checkOutput("rct8_ro", ro_enable, 8'h00);
    checkReg("rct8_status", 4'h1, 8'h15);
    checkReg("rct8_data", 4'h2, 8'h55);
    popData(gotByte);
    checkOutput("rct8_pop", gotByte, 8'h55);
    popData(gotByte);
    checkOutput("empty_pop_value", gotByte, 8'h00);
    checkReg("empty_pop_status", 4'h1, 8'h04);
    applyStimulus(4'h0, 8'h00);

    // FIFO clear with a push landing in the same cycle
    applyStimulus(4'h3, 8'h14);
    checkReg("rct_20", 4'h3, 8'h14);
    applyStimulus(4'h0, 8'h01);
    warmup(0);
    sendBits(8'h55, 8, 0);
    sendBits(8'hA3, 8, 0);
    sendBits(8'h3C, 8, 0);
    checkReg("clr_before", 4'h1, 8'h31);
    sendBits(8'h96, 7, 0);
    entropy_bit = 1'b1;
    applyStimulus(4'h0, 8'h03);
    checkReg("clr_status", 4'h1, 8'h00);
    checkOutput("clr_ro_enable", ro_enable, 8'h01);
    checkReg("clr_ctrl", 4'h0, 8'h01);

    // Async reset mid-collect with 2 bytes buffered
    sendBits(8'h55, 8, 0);
    sendBits(8'h55, 8, 0);
    checkReg("pre_rst_status", 4'h1, 8'h21);
    address = 4'h0;
    rst_n   = 1'b0;
    #1;
    checkOutput("arst_ro_enable", ro_enable, 8'h00);
    checkOutput("arst_byte_ready", byte_ready, 8'h00);
    checkOutput("arst_data_out", data_out, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkReg("arst_status", 4'h1, 8'h00);
    checkReg("arst_ctrl", 4'h0, 8'h00);
    checkReg("arst_rct", 4'h3, 8'h10);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
